// File: rtl/ddr3_bridge_pkg.sv
// Shared types and sizes for the DDR3 line bridge: line/word geometry and the
// transfer state encoding.
package ddr3_bridge_pkg;

  localparam int LINE_W   = 256;
  localparam int WORD_W   = 32;
  localparam int BEATS    = 8;
  localparam int LINE_OFS = 5;

  typedef enum logic [2:0] {
    IDLE,
    BEAT,
    GAP,
    DONE,
    DROP
  } state_t;

endpackage

// File: rtl/ddr3_ack_watchdog.sv
// Per-beat ack watchdog: counts cycles of an outstanding phy beat and flags
// expiry after TIMEOUT cycles without an ack. Used only with DDR3_LINE_BRIDGE_TIMEOUT_EN.
module ddr3_ack_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ack,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;
  logic          running;

  // start is asserted the cycle before a beat begins, so the count is 0 in its first cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      count   <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (ack || expire) begin
        running <= 1'b0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign expire = running && !ack && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ddr3_line_bridge.sv
// Splits 256-bit cache line reads/writes into eight 32-bit phy beats.
// Optional per-beat ack watchdog: define DDR3_LINE_BRIDGE_TIMEOUT_EN.
module ddr3_line_bridge
  import ddr3_bridge_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ctrl_addr_i,
  input  logic [LINE_W-1:0] ctrl_data_i,
  output logic [LINE_W-1:0] ctrl_data_o,
  input  logic              ctrl_we_i,
  input  logic              ctrl_rd_i,
  output logic              ctrl_ack_o,
  output logic [31:0]       phy_addr_o,
  output logic [WORD_W-1:0] phy_data_o,
  input  logic [WORD_W-1:0] phy_data_i,
  output logic              phy_we_o,
  output logic              phy_rd_o,
  input  logic              phy_ack_i,
  output logic              err_o
);

  state_t              state, next_state;
  logic [31:LINE_OFS]  line_addr;
  logic [LINE_W-1:0]   wline;
  logic                is_write;
  logic [2:0]          beat;
  logic                expire;
  logic                beat_done;
  logic                last_beat;
  logic                unused_bits;

  assign unused_bits = ^ctrl_addr_i[LINE_OFS-1:0];
  assign beat_done   = (state == BEAT) && (phy_ack_i || expire);
  assign last_beat   = (beat == 3'(BEATS - 1));

`ifdef DDR3_LINE_BRIDGE_TIMEOUT_EN
  logic beat_start;
  logic err_q;

  assign beat_start = (next_state == BEAT) && (state != BEAT);

  ddr3_ack_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .start  (beat_start),
    .ack    (phy_ack_i),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (expire) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign expire = 1'b0;
  assign err_o  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Every beat, including the last, is followed by one strobe-low GAP cycle before DONE
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (ctrl_rd_i || ctrl_we_i) next_state = BEAT;
      BEAT: if (beat_done) next_state = GAP;
      GAP:  next_state = last_beat ? DONE : BEAT;
      DONE: next_state = DROP;
      DROP: if (!ctrl_rd_i && !ctrl_we_i) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_addr   <= '0;
      wline       <= '0;
      is_write    <= 1'b0;
      beat        <= '0;
      ctrl_data_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl_rd_i || ctrl_we_i) begin
            line_addr <= ctrl_addr_i[31:LINE_OFS];
            is_write  <= ctrl_we_i && !ctrl_rd_i;
            beat      <= '0;
            if (ctrl_we_i && !ctrl_rd_i) begin
              wline <= ctrl_data_i;
            end
          end
        end
        BEAT: begin
          if (beat_done && !is_write) begin
            ctrl_data_o[{beat, 5'd0} +: WORD_W] <= phy_ack_i ? phy_data_i : '0;
          end
        end
        GAP: begin
          if (!last_beat) begin
            beat <= beat + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    phy_addr_o = '0;
    phy_data_o = '0;
    phy_we_o   = 1'b0;
    phy_rd_o   = 1'b0;
    ctrl_ack_o = 1'b0;
    case (state)
      BEAT: begin
        phy_addr_o = {line_addr, beat, 2'b00};
        phy_data_o = wline[{beat, 5'd0} +: WORD_W];
        phy_we_o   = is_write;
        phy_rd_o   = !is_write;
      end
      DONE: ctrl_ack_o = 1'b1;
      default: ;
    endcase
  end

endmodule
